// File: rtl/shift_unit_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shift_unit_seq_if
// Brief    : Handshake and operand bundle between issue logic and the
//            iterative shifter feeding ALU input B.
// Revision : 1.0
// ============================================================================
interface shift_unit_seq_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
);
  logic             start;
  logic             flush;
  logic [2:0]       Shift_OP;
  logic [WIDTH-1:0] Din;
  logic [AMT_W-1:0] Shift_Amt;
  logic             C;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] Dout;
  logic             shiftCout;

  modport master (
    output start, flush, Shift_OP, Din, Shift_Amt, C,
    input  ready, valid, Dout, shiftCout
  );

  modport slave (
    input  start, flush, Shift_OP, Din, Shift_Amt, C,
    output ready, valid, Dout, shiftCout
  );
endinterface
`default_nettype wire

// File: rtl/shift_unit_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shift_unit_seq
// Brief    : One-bit-per-clock ARM-style shifter (LSL/LSR/ASR/ROR/RRX)
//            producing ALU operand B and the shifter carry-out.
// Revision : 1.0
// ============================================================================
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  shift_unit_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int ROT_W = $clog2(WIDTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [2:0] c_OP_LSL = 3'd0;
  localparam logic [2:0] c_OP_LSR = 3'd1;
  localparam logic [2:0] c_OP_ASR = 3'd2;
  localparam logic [2:0] c_OP_ROR = 3'd3;
  localparam logic [2:0] c_OP_RRX = 3'd4;

  localparam logic [AMT_W-1:0] c_AMT_LOGIC = AMT_W'(WIDTH + 1);
  localparam logic [AMT_W-1:0] c_AMT_ARITH = AMT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_N_LOGIC   = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_N_ARITH   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_N_ONE     = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_dout;
  logic             r_cout;

  logic             w_accept;
  logic [CNT_W-1:0] w_n_load;
  logic             w_ror_wrap;
  logic             w_ready;
  logic             w_valid;

  // flush outranks start so a cancelled slot never launches a new op
  assign w_accept   = (r_state == c_IDLE) && bus.start && !bus.flush;
  assign w_ror_wrap = (bus.Shift_Amt != '0) && (bus.Shift_Amt[ROT_W-1:0] == '0);

  // Iteration count; logical shifts run one extra step so the carry clears
  always_comb begin
    w_n_load = '0;
    case (bus.Shift_OP)
      c_OP_LSL, c_OP_LSR:
        w_n_load = (bus.Shift_Amt > c_AMT_LOGIC) ? c_N_LOGIC : CNT_W'(bus.Shift_Amt);
      c_OP_ASR:
        w_n_load = (bus.Shift_Amt > c_AMT_ARITH) ? c_N_ARITH : CNT_W'(bus.Shift_Amt);
      c_OP_ROR:
        w_n_load = CNT_W'(bus.Shift_Amt[ROT_W-1:0]);
      default:
        w_n_load = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_n_load == '0) ? c_DONE : c_RUN;
        end
      end
      c_RUN: begin
        if (bus.flush) begin
          w_state_nxt = c_IDLE;
        end else if (r_cnt == c_N_ONE) begin
          w_state_nxt = c_DONE;
        end
      end
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      c_IDLE:  w_ready = 1'b1;
      c_DONE:  w_valid = !bus.flush;
      default: begin
        w_ready = 1'b0;
        w_valid = 1'b0;
      end
    endcase
  end

  // Zero-iteration fixups (RRX, ROR by a multiple of WIDTH, amount 0, pass)
  // are all resolved at accept, so DONE only has to present the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
      r_cout <= 1'b0;
      r_cnt  <= '0;
      r_op   <= '0;
    end else if (w_accept) begin
      r_op  <= bus.Shift_OP;
      r_cnt <= w_n_load;
      case (bus.Shift_OP)
        c_OP_RRX: begin
          r_dout <= {bus.C, bus.Din[WIDTH-1:1]};
          r_cout <= bus.Din[0];
        end
        c_OP_ROR: begin
          r_dout <= bus.Din;
          r_cout <= w_ror_wrap ? bus.Din[WIDTH-1] : bus.C;
        end
        default: begin
          r_dout <= bus.Din;
          r_cout <= bus.C;
        end
      endcase
    end else if ((r_state == c_RUN) && !bus.flush) begin
      r_cnt <= r_cnt - c_N_ONE;
      case (r_op)
        c_OP_LSL: begin
          r_cout <= r_dout[WIDTH-1];
          r_dout <= {r_dout[WIDTH-2:0], 1'b0};
        end
        c_OP_LSR: begin
          r_cout <= r_dout[0];
          r_dout <= {1'b0, r_dout[WIDTH-1:1]};
        end
        c_OP_ASR: begin
          r_cout <= r_dout[0];
          r_dout <= {r_dout[WIDTH-1], r_dout[WIDTH-1:1]};
        end
        c_OP_ROR: begin
          r_cout <= r_dout[0];
          r_dout <= {r_dout[0], r_dout[WIDTH-1:1]};
        end
        default: begin
          r_cout <= r_cout;
          r_dout <= r_dout;
        end
      endcase
    end
  end

  assign bus.ready     = w_ready;
  assign bus.valid     = w_valid;
  assign bus.Dout      = r_dout;
  assign bus.shiftCout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit_seq
// Brief    : Scoreboard bench for shift_unit_seq with an arithmetic reference.
// Revision : 1.0
// ============================================================================
module tb_shift_unit_seq;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  typedef struct {
    logic [31:0] d;
    logic        c;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  shift_unit_seq_if #(.WIDTH(32), .AMT_W(8)) bus ();

  shift_unit_seq #(.WIDTH(32), .AMT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic on the operand, not a bit-serial walk
  function automatic void model(input logic [2:0] op, input logic [31:0] din, input int amt,
                                input logic c, output logic [31:0] d, output logic co,
                                output int n);
    logic [63:0] r;
    int k;
    d = din;
    co = c;
    n = 0;
    r = '0;
    k = amt % 32;
    case (op)
      3'd0: begin
        n = (amt > 33) ? 33 : amt;
        if (amt > 32) begin d = '0; co = 1'b0; end
        else if (amt > 0) begin r = {32'b0, din} << amt; d = r[31:0]; co = r[32]; end
      end
      3'd1: begin
        n = (amt > 33) ? 33 : amt;
        if (amt > 32) begin d = '0; co = 1'b0; end
        else if (amt > 0) begin r = {din, 32'b0} >> amt; d = r[63:32]; co = r[31]; end
      end
      3'd2: begin
        n = (amt > 32) ? 32 : amt;
        if (amt >= 32) begin d = {32{din[31]}}; co = din[31]; end
        else if (amt > 0) begin d = $signed(din) >>> amt; co = din[amt-1]; end
      end
      3'd3: begin
        n = k;
        if (amt != 0 && k == 0) co = din[31];
        else if (k != 0) begin d = (din >> k) | (din << (32 - k)); co = din[k-1]; end
      end
      3'd4: begin
        d = {c, din[31:1]};
        co = din[0];
      end
      default: ;
    endcase
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected no pulse", cyc);
        end else begin
          e = sb.pop_front();
          check("dout", bus.Dout, e.d);
          check("cout", {31'b0, bus.shiftCout}, {31'b0, e.c});
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] din, input int amt,
                       input logic c, input bit push, input bit poke);
    int waited;
    int busy;
    logic [31:0] ed;
    logic ec;
    int n;
    exp_t e;
    @(negedge clk);
    waited = 0;
    while (bus.ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (bus.ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready=%b expected 1", bus.ready);
    end
    bus.start = 1'b1;
    bus.Shift_OP = op;
    bus.Din = din;
    bus.Shift_Amt = 8'(amt);
    bus.C = c;
    model(op, din, amt, c, ed, ec, n);
    e.d = ed;
    e.c = ec;
    e.acc = cyc;
    e.lat = n + 1;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.Din = $urandom;
    bus.C = 1'($urandom);
    bus.Shift_Amt = 8'($urandom);
    if (poke) begin
      busy = 0;
      while (bus.ready !== 1'b1 && busy < 100) begin
        bus.start = 1'b1;
        bus.Shift_OP = 3'($urandom);
        bus.Din = $urandom;
        bus.Shift_Amt = 8'($urandom);
        busy++;
        @(negedge clk);
      end
      bus.start = 1'b0;
      check("busy_cycles", 32'(busy), 32'(n + 1));
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (bus.ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int amt;
    int sel;
    tests = 0;
    fails = 0;
    cyc = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.Shift_OP = '0;
    bus.Din = '0;
    bus.Shift_Amt = '0;
    bus.C = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, bus.ready}, 32'd1);
    check("rst_valid", {31'b0, bus.valid}, 32'd0);
    check("rst_dout", bus.Dout, 32'd0);
    check("rst_cout", {31'b0, bus.shiftCout}, 32'd0);
    rst = 1'b0;

    issue(3'd0, 32'h8000_0001, 1, 1'b0, 1, 0);
    issue(3'd1, 32'h8000_0000, 32, 1'b0, 1, 0);
    issue(3'd1, 32'h8000_0000, 40, 1'b1, 1, 0);
    issue(3'd2, 32'h8000_00F0, 4, 1'b1, 1, 0);
    issue(3'd2, 32'h8000_00F0, 200, 1'b0, 1, 0);
    issue(3'd3, 32'h0000_0001, 1, 1'b0, 1, 0);
    issue(3'd3, 32'h8765_4321, 32, 1'b0, 1, 0);
    issue(3'd4, 32'h0000_0003, 0, 1'b1, 1, 0);
    issue(3'd0, 32'h0000_1234, 0, 1'b1, 1, 1);
    issue(3'd2, 32'hC000_0005, 7, 1'b0, 1, 1);
    issue(3'd6, 32'hDEAD_BEEF, 9, 1'b1, 1, 1);

    // flush mid-RUN: no valid, back in IDLE the next cycle
    issue(3'd2, 32'h8000_1234, 20, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_ready", {31'b0, bus.ready}, 32'd1);

    // flush beats a simultaneous start in IDLE
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.Shift_OP = 3'd0;
    bus.Shift_Amt = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_ready", {31'b0, bus.ready}, 32'd1);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: amt = $urandom_range(0, 8);
        1: amt = $urandom_range(28, 36);
        2: amt = $urandom_range(0, 255);
        default: amt = 32 * $urandom_range(0, 3);
      endcase
      issue(3'($urandom_range(0, 7)), $urandom, amt, 1'($urandom), 1, bit'($urandom_range(0, 1)));
    end
    wait_idle();

    // asynchronous reset in the middle of a run
    issue(3'd2, 32'hF0F0_0F0F, 20, 1'b1, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_dout", bus.Dout, 32'd0);
    check("arst_cout", {31'b0, bus.shiftCout}, 32'd0);
    check("arst_ready", {31'b0, bus.ready}, 32'd1);
    check("arst_valid", {31'b0, bus.valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(3'd1, 32'h0000_00F0, 4, 1'b1, 1, 0);
    wait_idle();

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Iterative barrel-shifter stage directly upstream of the ALU; produces the shifted second operand (ALU input B) and the shifter carry-out (ALU input shiftCout).
- Implements ARM-style LSL/LSR/ASR/ROR/RRX with register-specified amounts, shifting one bit per clock.
- Uses a start/ready/valid handshake. Result and carry stay registered until the next accepted operation.

Parameters:
- WIDTH, 32, data width; amount clamp rules below assume 32.
- AMT_W, 8, shift-amount width; only the bottom byte is meaningful, as for register shifts.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; accepted only when ready=1.
- flush  input  1  synchronous cancel of the in-flight operation.
- Shift_OP  input  3  0=LSL, 1=LSR, 2=ASR, 3=ROR, 4=RRX, 5-7=pass (Dout=Din, carry=C).
- Din  input  WIDTH  operand to shift, sampled on accept.
- Shift_Amt  input  AMT_W  shift amount, sampled on accept.
- C  input  1  current carry flag, sampled on accept.
- ready  output  1  high in IDLE.
- valid  output  1  one-cycle pulse when Dout and shiftCout are final.
- Dout  output  WIDTH  shifted result to ALU B.
- shiftCout  output  1  shifter carry-out to ALU.

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE, ready=1, valid=0, Dout=0, shiftCout=0, counter=0.
- States: IDLE, RUN, DONE.
- IDLE with start=1 (edge E0):
  - Latch Din into Dout and C into shiftCout.
  - Load counter n per the rules below. Go to RUN if n>0, else DONE.
  - ready drops the cycle after E0.
- Iteration count n:
  - LSL, LSR: n = min(Shift_Amt, 33).
  - ASR: n = min(Shift_Amt, 32).
  - ROR: n = Shift_Amt mod 32.
  - RRX, pass: n = 0.
- RUN, one shift per cycle, then counter decrements:
  - LSL: shiftCout <= Dout[31]; Dout <= Dout<<1.
  - LSR: shiftCout <= Dout[0]; Dout <= Dout>>1.
  - ASR: shiftCout <= Dout[0]; Dout <= {Dout[31], Dout[31:1]}.
  - ROR: shiftCout <= Dout[0]; Dout <= {Dout[0], Dout[31:1]}.
  - When the counter reaches 0 after the decrement, go to DONE.
- DONE fixups, applied on entry (one-cycle ops):
  - RRX: Dout = {C, Din[31:1]}, shiftCout = Din[0].
  - ROR with Shift_Amt≠0 and Shift_Amt mod 32 = 0: Dout = Din, shiftCout = Din[31].
  - Shift_Amt=0 (any op except RRX): Dout = Din, shiftCout = C.
- DONE: valid=1 for exactly one cycle, then IDLE.
  - valid is asserted n+1 cycles after the accept edge.
  - Dout and shiftCout hold their values until the next accept.
- Clamp consequences:
  - LSL/LSR by 32: result 0, carry = Din[0] (LSL) or Din[31] (LSR).
  - LSL/LSR by more than 32: result 0, carry 0.
  - ASR by 32 or more: result all sign bits, carry = sign.
- start while not in IDLE: ignored, no queuing. start in the DONE cycle is also ignored.
- flush:
  - In RUN or DONE: go to IDLE next edge, valid stays 0, Dout and shiftCout keep their partial values.
  - In IDLE: no effect.
  - flush and start together in IDLE: flush wins, start is not accepted.
- Operand inputs are ignored after accept; changing Din, C or Shift_Amt mid-operation has no effect.

Test Plan:
- Reset, then LSL Din=0x8000_0001 amt=1, C=0 -> valid at cycle 2 after accept, Dout=0x0000_0002, shiftCout=1.
- LSR Din=0x8000_0000 amt=32 -> Dout=0, shiftCout=1, valid 33 cycles after accept; LSR amt=40 -> Dout=0, shiftCout=0, valid 34 cycles after accept.
- ASR Din=0x8000_00F0 amt=4 -> Dout=0xF800_000F, shiftCout=0; ASR amt=200 -> Dout=0xFFFF_FFFF, shiftCout=1.
- ROR Din=0x0000_0001 amt=1 -> Dout=0x8000_0000, shiftCout=1; ROR amt=32 -> Dout=Din, shiftCout=Din[31]; RRX Din=0x3, C=1 -> Dout=0x8000_0001, shiftCout=1, valid 1 cycle after accept.
- amt=0 LSL with C=1, Din=0x1234 -> Dout=0x1234, shiftCout=1; start pulses while busy are ignored (ready=0 throughout, single valid pulse).
- ASR amt=20, flush at cycle 5 -> no valid, ready=1 next cycle; repeat with async rst mid-RUN -> Dout=0, shiftCout=0, ready=1 immediately.
